// File: rtl/rr_resource_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_resource_arbiter_pkg
// Purpose  : Shared state encodings and index helper for the round-robin
//            resource arbiter.
// Revision : 1.0  initial release
// ============================================================================
package rr_resource_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } arb_state_t;

   // Modular add for indices already below n; avoids a divider.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_resource_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: first requester at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
   import rr_resource_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         j = wrap_add(int'(ptr), k, N);
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_resource_arbiter
// Purpose  : Round-robin owner arbitration for a shared register stage with
//            bounded tenure and a one-cycle cool-down between owners.
// Revision : 1.0  initial release
// ============================================================================
module rr_resource_arbiter
   import rr_resource_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 timeout
);

   localparam int             c_IW       = $clog2(N);
   localparam int             c_CW       = $clog2(HOLD_MAX);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(HOLD_MAX - 1);
   localparam logic [N-1:0]   c_ONE      = {{(N-1){1'b0}}, 1'b1};

   arb_state_t       r_state, w_state_n;
   logic [c_IW-1:0]  r_ptr,   w_ptr_n;
   logic [c_CW-1:0]  r_cnt,   w_cnt_n;
   logic [N-1:0]     w_gnt_n;
   logic [c_IW-1:0]  w_id_n;
   logic             w_busy_n;
   logic             w_timeout_n;

   logic             w_valid;
   logic [c_IW-1:0]  w_idx;
   logic             w_rel_norm;
   logic             w_rel_force;

   rr_pick #(.N(N), .IW(c_IW)) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_valid),
      .idx   (w_idx)
   );

   // Only the owner's bits matter; normal release wins over the hold limit.
   assign w_rel_norm  = !req[gnt_id] || done[gnt_id];
   assign w_rel_force = !w_rel_norm && (r_cnt == c_CNT_LAST);

   always_comb begin
      w_state_n   = r_state;
      w_ptr_n     = r_ptr;
      w_cnt_n     = r_cnt;
      w_gnt_n     = gnt;
      w_id_n      = gnt_id;
      w_busy_n    = busy;
      w_timeout_n = 1'b0;
      case (r_state)
         IDLE, COOL: begin
            if (w_valid) begin
               w_state_n = GRANT;
               w_gnt_n   = c_ONE << w_idx;
               w_id_n    = w_idx;
               w_busy_n  = 1'b1;
               w_cnt_n   = '0;
            end else begin
               w_state_n = IDLE;
               w_gnt_n   = '0;
               w_id_n    = '0;
               w_busy_n  = 1'b0;
            end
         end
         GRANT: begin
            if (w_rel_norm || w_rel_force) begin
               w_state_n   = COOL;
               w_gnt_n     = '0;
               w_id_n      = '0;
               w_busy_n    = 1'b0;
               w_ptr_n     = c_IW'(wrap_add(int'(gnt_id), 1, N));
               w_timeout_n = w_rel_force;
            end else begin
               w_cnt_n = r_cnt + c_CW'(1);
            end
         end
         default: begin
            w_state_n = IDLE;
            w_gnt_n   = '0;
            w_id_n    = '0;
            w_busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_ptr   <= w_ptr_n;
         r_cnt   <= w_cnt_n;
         gnt     <= w_gnt_n;
         gnt_id  <= w_id_n;
         busy    <= w_busy_n;
         timeout <= w_timeout_n;
      end
   end

endmodule

`default_nettype wire
